// File: rtl/boot_loader_if.sv
// Byte-stream handshake and instruction-memory write port shared by the boot loader
// and whatever feeds it bytes / observes its writes.
interface boot_loader_if #(
   parameter int ADDR_W = 8
) ();
   logic [7:0]        rx_data;
   logic              rx_valid;
   logic              rx_ready;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_wdata;

   modport master (
      output rx_data, rx_valid,
      input  rx_ready, imem_we, imem_addr, imem_wdata
   );

   modport slave (
      input  rx_data, rx_valid,
      output rx_ready, imem_we, imem_addr, imem_wdata
   );
endinterface

// File: rtl/boot_loader.sv
// Serial boot loader: assembles a length-prefixed, checksummed byte frame into 32-bit
// little-endian words, writes them to instruction memory and releases the core once verified.
module boot_loader #(
   parameter int ADDR_W = 8
) (
   input  logic          clk,
   input  logic          reset,
   boot_loader_if.slave  bus,
   input  logic          reload,
   output logic          core_run,
   output logic          done,
   output logic          error
);
   typedef enum logic [2:0] {
      S_LEN_LO, S_LEN_HI, S_DATA, S_CSUM, S_RUN, S_ERR
   } state_t;

   localparam logic [16:0] N_MAX = 17'(1) << ADDR_W;

   state_t            state, state_nxt;
   logic [7:0]        len_lo;
   logic [ADDR_W:0]   n_words;
   logic [ADDR_W:0]   idx;
   logic [ADDR_W:0]   idx_nxt;
   logic [1:0]        lane;
   logic [7:0]        sum;
   logic [23:0]       word_buf;
   logic              rdy;
   logic              accept;
   logic [16:0]       n_full;

   logic              wr_vld_p1;
   logic [ADDR_W-1:0] wr_addr_p1;
   logic [31:0]       wr_data_p1;

   function automatic logic [7:0] sum_wrap(input logic [7:0] a, input logic [7:0] b);
      return a + b;
   endfunction

   assign rdy     = (state == S_LEN_LO) || (state == S_LEN_HI) ||
                    (state == S_DATA)   || (state == S_CSUM);
   assign accept  = bus.rx_valid & rdy;
   assign n_full  = {1'b0, bus.rx_data, len_lo};
   assign idx_nxt = idx + (ADDR_W+1)'(1);

   assign bus.rx_ready   = rdy;
   assign bus.imem_we    = wr_vld_p1;
   assign bus.imem_addr  = wr_addr_p1;
   assign bus.imem_wdata = wr_data_p1;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= S_LEN_LO;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      core_run  = 1'b0;
      done      = 1'b0;
      error     = 1'b0;
      case (state)
         S_LEN_LO: if (accept) state_nxt = S_LEN_HI;
         S_LEN_HI: begin
            if (accept) begin
               if (n_full > N_MAX)       state_nxt = S_ERR;
               else if (n_full == 17'd0) state_nxt = S_CSUM;
               else                      state_nxt = S_DATA;
            end
         end
         S_DATA: begin
            if (accept && lane == 2'd3 && idx_nxt == n_words) state_nxt = S_CSUM;
         end
         S_CSUM: begin
            if (accept) state_nxt = (bus.rx_data == sum) ? S_RUN : S_ERR;
         end
         S_RUN: begin
            core_run = 1'b1;
            done     = 1'b1;
            if (reload) state_nxt = S_LEN_LO;
         end
         S_ERR: begin
            error = 1'b1;
            if (reload) state_nxt = S_LEN_LO;
         end
         default: state_nxt = S_LEN_LO;
      endcase
   end

   // p1: word assembly and registered memory write
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         len_lo     <= '0;
         n_words    <= '0;
         idx        <= '0;
         lane       <= '0;
         sum        <= '0;
         word_buf   <= '0;
         wr_vld_p1  <= 1'b0;
         wr_addr_p1 <= '0;
         wr_data_p1 <= '0;
      end else begin
         wr_vld_p1 <= 1'b0;
         if (accept) begin
            case (state)
               S_LEN_LO: len_lo <= bus.rx_data;
               S_LEN_HI: begin
                  // Cleared on every length so a zero-length frame after reload checks against 0.
                  n_words <= n_full[ADDR_W:0];
                  idx     <= '0;
                  lane    <= '0;
                  sum     <= '0;
               end
               S_DATA: begin
                  sum  <= sum_wrap(sum, bus.rx_data);
                  lane <= lane + 2'd1;
                  case (lane)
                     2'd0: word_buf[7:0]   <= bus.rx_data;
                     2'd1: word_buf[15:8]  <= bus.rx_data;
                     2'd2: word_buf[23:16] <= bus.rx_data;
                     default: begin
                        wr_vld_p1  <= 1'b1;
                        wr_addr_p1 <= idx[ADDR_W-1:0];
                        wr_data_p1 <= {bus.rx_data, word_buf};
                        idx        <= idx_nxt;
                     end
                  endcase
               end
               default: ;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_boot_loader.sv
// Scoreboard bench for boot_loader: expected writes are queued as frames are sent and a
// monitor checks every imem_we pulse against the queue.
module tb_boot_loader;
   logic clk = 1'b0;
   logic reset = 1'b0;
   logic reload = 1'b0;
   logic core_run, done, error;
   int   total = 0;
   int   bad = 0;

   logic [39:0] exp_q[$];
   logic [7:0]  pl[$];
   logic [39:0] e;

   boot_loader_if #(.ADDR_W(8)) bif ();

   boot_loader #(.ADDR_W(8)) dut (
      .clk      (clk),
      .reset    (reset),
      .bus      (bif.slave),
      .reload   (reload),
      .core_run (core_run),
      .done     (done),
      .error    (error)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (reset && bif.imem_we === 1'b1) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_write: got addr=%0h data=%0h want none",
                     bif.imem_addr, bif.imem_wdata);
         end else begin
            e = exp_q.pop_front();
            if ({bif.imem_addr, bif.imem_wdata} !== e) begin
               bad++;
               $display("FAIL write: got addr=%0h data=%0h want addr=%0h data=%0h",
                        bif.imem_addr, bif.imem_wdata, e[39:32], e[31:0]);
            end
         end
      end
   end

   task automatic send(input logic [7:0] b, input int gap);
      repeat (gap) begin
         @(negedge clk);
         bif.rx_valid = 1'b0;
         bif.rx_data  = 8'($urandom);
      end
      @(negedge clk);
      bif.rx_valid = 1'b1;
      bif.rx_data  = b;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         bif.rx_valid = 1'b0;
      end
   endtask

   task automatic pulse_reload();
      @(negedge clk);
      bif.rx_valid = 1'b0;
      reload = 1'b1;
      @(posedge clk);
      #1;
      reload = 1'b0;
   endtask

   task automatic send_frame(input logic [15:0] n, input logic [7:0] cs, input bit throttle);
      int g;
      send(n[7:0], 0);
      send(n[15:8], 0);
      for (int i = 0; i < pl.size(); i++) begin
         if (i % 4 == 0)
            exp_q.push_back({8'(i / 4), pl[i+3], pl[i+2], pl[i+1], pl[i]});
         g = 0;
         if (throttle) g = (i % 4 == 3) ? 3 : int'($urandom_range(0, 2));
         send(pl[i], g);
      end
      check("run_before_csum", core_run, 0);
      send(cs, throttle ? 2 : 0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_rx_ready"}, bif.rx_ready, 1);
      check({tag, "_imem_we"}, bif.imem_we, 0);
      check({tag, "_imem_addr"}, bif.imem_addr, 0);
      check({tag, "_imem_wdata"}, bif.imem_wdata, 0);
      check({tag, "_core_run"}, core_run, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_error"}, error, 0);
   endtask

   initial begin
      bif.rx_valid = 1'b0;
      bif.rx_data  = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      @(negedge clk);
      reset = 1'b1;

      // happy path: checksum is 0x01+0x02+0x03+0x04+0xAA+0xBB+0xCC+0xDD = 0x318 -> 0x18
      pl = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
      send_frame(16'd2, 8'h18, 1'b0);
      check("happy_core_run", core_run, 1);
      check("happy_done", done, 1);
      check("happy_rx_ready", bif.rx_ready, 0);
      check("happy_error", error, 0);
      check("happy_hold_addr", bif.imem_addr, 1);
      check("happy_hold_data", bif.imem_wdata, 32'hDDCCBBAA);

      // bytes offered in RUN are not consumed
      @(negedge clk);
      bif.rx_valid = 1'b1;
      bif.rx_data  = 8'h55;
      repeat (4) @(posedge clk);
      #1;
      check("run_ignore_core_run", core_run, 1);
      check("run_ignore_rx_ready", bif.rx_ready, 0);
      pulse_reload();
      check("reload_core_run", core_run, 0);
      check("reload_done", done, 0);
      check("reload_rx_ready", bif.rx_ready, 1);

      // bad checksum
      send_frame(16'd2, 8'h19, 1'b0);
      check("badcs_error", error, 1);
      check("badcs_core_run", core_run, 0);
      check("badcs_done", done, 0);
      check("badcs_rx_ready", bif.rx_ready, 0);
      pulse_reload();
      check("badcs_reload_error", error, 0);
      check("badcs_reload_rx_ready", bif.rx_ready, 1);

      // throttled reload of the good frame
      send_frame(16'd2, 8'h18, 1'b1);
      check("throttle_core_run", core_run, 1);
      check("throttle_done", done, 1);
      check("throttle_hold_data", bif.imem_wdata, 32'hDDCCBBAA);
      pulse_reload();

      // length overflow: N = 0x0101 > 256
      send(8'h01, 0);
      send(8'h01, 0);
      check("ovf_error", error, 1);
      check("ovf_rx_ready", bif.rx_ready, 0);
      idle(4);
      check("ovf_no_writes", exp_q.size(), 0);
      pulse_reload();
      check("ovf_reload_error", error, 0);

      // zero-length image
      pl.delete();
      send_frame(16'd0, 8'h00, 1'b0);
      check("zero_core_run", core_run, 1);
      check("zero_done", done, 1);
      pulse_reload();

      // reload during DATA is ignored; checksum 0x11+0x22+0x33+0x44 = 0xAA
      exp_q.push_back({8'h00, 32'h44332211});
      send(8'h01, 0);
      send(8'h00, 0);
      send(8'h11, 0);
      send(8'h22, 0);
      pulse_reload();
      check("data_reload_rx_ready", bif.rx_ready, 1);
      check("data_reload_error", error, 0);
      send(8'h33, 0);
      send(8'h44, 0);
      send(8'hAA, 0);
      check("data_reload_core_run", core_run, 1);
      pulse_reload();

      // reset after 5 payload bytes
      exp_q.push_back({8'h00, 32'h04030201});
      send(8'h02, 0);
      send(8'h00, 0);
      for (int i = 1; i <= 5; i++) send(8'(i), 0);
      reset = 1'b0;
      #1;
      check_reset_outputs("midreset");
      @(negedge clk);
      bif.rx_valid = 1'b0;
      reset = 1'b1;
      pl = '{8'h10, 8'h20, 8'h30, 8'h40};
      send_frame(16'd1, 8'hA0, 1'b0);
      check("fresh_core_run", core_run, 1);
      check("fresh_addr", bif.imem_addr, 0);
      check("fresh_data", bif.imem_wdata, 32'h40302010);

      idle(4);
      check("queue_empty", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
